// File: rtl/or8way_scan_ctrl_pkg.sv
// or8way_scan_ctrl_pkg: shared state encoding and sizing helpers for the byte-serial OR scanner
package or8way_scan_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int nb_of(input int width);
    return width / 8;
  endfunction
  function automatic int idx_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction
endpackage

// File: rtl/g_OR8WAY.sv
// g_OR8WAY: the single shared 8-input OR tree
module g_OR8WAY (
  input  logic [7:0] a,
  output logic       y
);
  assign y = |a;
endmodule

// File: rtl/or8way_scan_ctrl.sv
// or8way_scan_ctrl: nonzero flag and lowest nonzero byte index of a word, one byte per clock through one OR8 tree
module or8way_scan_ctrl
  import or8way_scan_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_any,
  output logic                              out_zero,
  output logic [idx_width(WIDTH/8)-1:0]     out_idx,
  output logic                              busy
);
  localparam int NB = nb_of(WIDTH);
  localparam int IW = idx_width(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
    $fatal(1, "or8way_scan_ctrl: WIDTH must be a nonzero multiple of 8");
  end
  state_t state, state_nx;
  logic [WIDTH-1:0]   word;
  logic [NB-1:0][7:0] bytes;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      hit_idx;
  logic               any;
  logic [7:0]         byte_sel;
  logic               or_out;
  logic               last;
  logic               finish;
  assign bytes    = word;
  assign byte_sel = bytes[idx];
  assign last     = idx == LAST;
  assign finish   = (or_out & EARLY_EXIT) | last;
  g_OR8WAY u_or8 (
    .a(byte_sel),
    .y(or_out)
  );
  // next-state decode; unused encoding falls back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? SCAN : IDLE;
      SCAN:    state_nx = finish ? DONE : SCAN;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // capture word on accept, walk bytes in SCAN, latch only the first hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word    <= '0;
      idx     <= '0;
      any     <= 1'b0;
      hit_idx <= '0;
    end else if (state == IDLE && in_valid) begin
      word    <= in_data;
      idx     <= '0;
      any     <= 1'b0;
      hit_idx <= '0;
    end else if (state == SCAN) begin
      if (or_out && !any) begin
        any     <= 1'b1;
        hit_idx <= idx;
      end
      if (!finish) idx <= idx + IW'(1);
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_any   = any;
  assign out_zero  = ~any;
  assign out_idx   = hit_idx;
endmodule

// File: tb/tb_or8way_scan_ctrl.sv
// tb_or8way_scan_ctrl: scoreboard bench for two configurations (16-bit early exit, 32-bit full scan)
module tb_or8way_scan_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int W  = g ? 32 : 16;
    localparam bit EE = g ? 1'b0 : 1'b1;
    localparam int NB = W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    typedef struct {
      bit any;
      int idx;
      int lat;
      int acc;
    } exp_t;
    logic reset_n, in_valid, in_ready, out_valid, out_ready, out_any, out_zero, busy;
    logic [W-1:0]  in_data;
    logic [IW-1:0] out_idx;
    exp_t q[$];
    exp_t cur;
    int cyc = 0;
    int mode = 1;
    logic pv = 1'b0;
    or8way_scan_ctrl #(.WIDTH(W), .EARLY_EXIT(EE)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_any(out_any), .out_zero(out_zero), .out_idx(out_idx), .busy(busy)
    );
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
      #1;
      out_ready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    function automatic exp_t model(input logic [W-1:0] w, input int acc);
      exp_t e;
      int j = -1;
      for (int k = 0; k < NB; k++)
        if (j < 0 && ((w >> (8 * k)) & W'(8'hFF)) != '0) j = k;
      e.any = j >= 0;
      e.idx = e.any ? j : 0;
      e.lat = (e.any && EE) ? j + 1 : NB;
      e.acc = acc;
      return e;
    endfunction
    always @(negedge clk) begin
      if (reset_n === 1'b1) begin
        if (out_valid) begin
          chk($sformatf("w%0d in_ready_in_done", W), in_ready, 1'b0);
          if (!pv) begin
            if (q.size() == 0) begin
              checks++;
              fails++;
              $display("FAIL w%0d unexpected_result actual=1 required=0", W);
            end else begin
              cur = q.pop_front();
              chk($sformatf("w%0d latency", W), cyc - cur.acc, cur.lat);
            end
          end
          chk($sformatf("w%0d out_any", W), out_any, cur.any);
          chk($sformatf("w%0d out_zero", W), out_zero, !cur.any);
          chk($sformatf("w%0d out_idx", W), out_idx, cur.idx);
        end
        pv = out_valid;
      end else pv = 1'b0;
    end
    task automatic send(input logic [W-1:0] w, input bit hold);
      bit ok = 0;
      in_data = w;
      in_valid = 1'b1;
      for (int t = 0; t < 400 && !ok; t++) begin
        @(negedge clk);
        ok = in_ready;
      end
      if (!ok) begin
        checks++;
        fails++;
        $display("FAIL w%0d accept_timeout actual=0 required=1", W);
        in_valid = 1'b0;
        return;
      end
      q.push_back(model(w, cyc + 1));
      @(posedge clk);
      #1;
      in_valid = hold;
      in_data = W'({$urandom, $urandom});
    endtask
    task automatic wait_valid();
      bit ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        ok = out_valid;
      end
      if (!ok) begin
        checks++;
        fails++;
        $display("FAIL w%0d valid_timeout actual=0 required=1", W);
      end
    endtask
    initial begin
      logic [31:0] tbl[6] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_8000,
                              32'h0100_4000, 32'hFF00_0000, 32'h0000_FF00};
      logic [W-1:0] w;
      reset_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("w%0d rst_busy", W), busy, 1'b0);
      chk($sformatf("w%0d rst_out_valid", W), out_valid, 1'b0);
      chk($sformatf("w%0d rst_in_ready", W), in_ready, 1'b1);
      chk($sformatf("w%0d rst_out_zero", W), out_zero, 1'b1);
      chk($sformatf("w%0d rst_out_idx", W), out_idx, '0);
      reset_n = 1'b1;
      foreach (tbl[i]) begin
        w = tbl[i][W-1:0];
        send(w, i < 5);
      end
      wait_valid();
      mode = 2;
      repeat (3) @(posedge clk);
      #1;
      send(W'(32'h0000_0100), 1'b1);
      wait_valid();
      repeat (5) begin
        @(negedge clk);
        chk($sformatf("w%0d stall_valid", W), out_valid, 1'b1);
      end
      w = W'(32'h0000_0003);
      in_data = w;
      mode = 1;
      send(w, 1'b0);
      wait_valid();
      mode = 0;
      for (int i = 0; i < 200; i++) begin
        for (int k = 0; k < NB; k++) begin
          w = w >> 8;
          w[W-1 -: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        end
        if ($urandom_range(0, 9) == 0) w = '0;
        send(w, i < 199);
      end
      for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge clk);
      chk($sformatf("w%0d drained", W), q.size(), 0);
      repeat (4) @(posedge clk);
      mode = 1;
      #1;
      send('0, 1'b0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk($sformatf("w%0d midrst_busy", W), busy, 1'b0);
      chk($sformatf("w%0d midrst_out_valid", W), out_valid, 1'b0);
      chk($sformatf("w%0d midrst_in_ready", W), in_ready, 1'b1);
      chk($sformatf("w%0d midrst_out_any", W), out_any, 1'b0);
      q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      send(W'(8'hFF) << (W - 8), 1'b0);
      for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk($sformatf("w%0d final_drained", W), q.size(), 0);
      chk($sformatf("w%0d final_idx", W), out_idx, NB - 1);
      done_cnt++;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=2", done_cnt);
    $fatal(1, "timeout");
  end
  initial begin
    wait (done_cnt == 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/or8way_scan_ctrl.md
# or8way_scan_ctrl

Sequencer that computes the OR-reduction (nonzero flag) of a WIDTH-bit word by time-multiplexing a single existing `g_OR8WAY` instance over the word's bytes, one byte per clock. It also reports the index of the lowest nonzero byte. It sits between a word producer (ALU zero-flag path, memory-scan logic) and a consumer, with valid/ready handshakes on both sides. It trades latency for reuse of one 8-input OR tree.

## Interface
- `WIDTH`, 16: input word width; multiple of 8, ≥ 8. NB = WIDTH/8 bytes.
- `EARLY_EXIT`, 1: 1 = stop scanning at the first nonzero byte; 0 = always scan all NB bytes.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WIDTH  word to reduce.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_any`  out  1  1 = word nonzero.
- `out_zero`  out  1  always ~`out_any` while `out_valid`.
- `out_idx`  out  max(1,$clog2(NB))  lowest nonzero byte index; 0 when `out_any`=0.
- `busy`  out  1  high in SCAN or DONE.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, register `in_data`, clear the byte counter `idx`, clear `out_any`/`out_idx`, then go to SCAN.
- SCAN: byte `idx` of the captured word (bits 8·idx+7 : 8·idx) drives the shared `g_OR8WAY`. At each edge:
  - OR result 1 and `out_any`=0: set `out_any`=1 and `out_idx`=idx.
  - Go to DONE if (OR result 1 and `EARLY_EXIT`) or idx = NB−1. Otherwise idx increments.
- DONE: `out_valid`=1; `out_any`, `out_zero`, `out_idx` are held stable. On `out_valid & out_ready`, go to IDLE.
- There is no overlap: `in_ready`=0 in SCAN and DONE. `in_valid` is ignored outside IDLE.
- With `EARLY_EXIT`=0, `out_idx` still reports the lowest nonzero byte. Later nonzero bytes do not overwrite it.
- `idx` never exceeds NB−1; the counter is never allowed to wrap.
- `in_data` changing after acceptance has no effect (captured copy is used).
- Reset (any state, including mid-SCAN):
  - state = IDLE, idx = 0, captured word = 0.
  - `out_any`=0, `out_idx`=0, `out_valid`=0, `busy`=0, `in_ready`=1, `out_zero`=1.
  - Any in-flight word is dropped and no result is emitted.

## Timing
- The acceptance edge is E0. Byte k is examined in the cycle after edge E(k).
- Latency: `out_valid` rises after edge E(k+1), where k is the last byte examined.
  - Zero word: k = NB−1, so latency is NB cycles.
  - `EARLY_EXIT`=1 and lowest nonzero byte j: latency is j+1 cycles.
- Throughput: at best one word per latency+2 cycles (DONE→IDLE edge, then an IDLE accept cycle). With `out_ready` tied high, DONE lasts exactly one cycle.
- `in_ready`, `out_valid` and `busy` are decoded combinationally from registered state only; there is no combinational in→out path.
- `out_zero` = ~`out_any`, combinational.

## Structure
- Shared package holds:
  - state encoding constants IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - byte-count helper NB = WIDTH/8 and the index-width function.
- Sub-module: exactly one `g_OR8WAY` instance. No other reduction logic is permitted; the byte mux feeds it.
- Elaboration-time check: WIDTH%8 ≠ 0 or WIDTH < 8 is a fatal error.

## Test plan
- WIDTH=16, EARLY_EXIT=1, `in_data`=16'h0000, `out_ready`=1 → `out_valid` 2 cycles after accept; `out_any`=0, `out_zero`=1, `out_idx`=0.
- WIDTH=16, EARLY_EXIT=1, `in_data`=16'h0001 → `out_valid` after 1 cycle, `out_any`=1, `out_idx`=0. Same setup with `in_data`=16'h8000 → `out_valid` after 2 cycles, `out_idx`=1.
- WIDTH=32, EARLY_EXIT=0, `in_data`=32'h0100_4000 → `out_valid` after 4 cycles, `out_any`=1, `out_idx`=1.
- Backpressure: `out_ready`=0 for 5 cycles in DONE with `in_valid` held high and new data → outputs stable, `in_ready`=0, nothing accepted. Release `out_ready` → returns to IDLE; the next word is accepted one cycle later.
- Reset mid-op: WIDTH=32, zero word, assert `reset_n`=0 during byte 2 → `busy`=0, `out_valid`=0, `in_ready`=1 immediately (async). After release, a new word 32'hFF00_0000 yields `out_idx`=3.
- Back-to-back random stream of 200 words, random `out_ready` stalls → every result matches |word and lowest nonzero byte; no words lost or duplicated.
